// File: rtl/ram_pkg.sv
// ram_pkg: shared widths, word/address types and the reset value for the bidirectional RAM
package ram_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    localparam data_t RESET_WORD = 8'h00;
endpackage

// File: rtl/ram_array.sv
// ram_array: 2**ADDR_W x DATA_W storage with synchronous write/clear and a read port
// Read port is combinational by default, registered when RAM_OUTREG_EN is defined.
module ram_array import ram_pkg::*; #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    // Reset clears every word and takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(RESET_WORD);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
`ifdef RAM_OUTREG_EN
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk) begin
        rd_q <= !rst_n ? DATA_W'(RESET_WORD) : mem[raddr];
    end
    assign rdata = rd_q;
`else
    assign rdata = mem[raddr];
`endif
endmodule

// File: rtl/bidir_ram.sv
// bidir_ram: single-port RAM on a shared tristate bus; write=0 stores the bus, write=1 drives it
// Define RAM_OUTREG_EN for a registered (one-cycle latency) read path.
module bidir_ram import ram_pkg::*; #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              write
);
    logic [DATA_W-1:0] rdata;
    ram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (!write),
        .waddr (address),
        .wdata (data),
        .raddr (address),
        .rdata (rdata)
    );
    // Bus enable is purely combinational so the bus is released the instant write falls.
    assign data = (rst_n && write) ? rdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_bidir_ram.sv
// tb_bidir_ram: directed self-checking bench for bidir_ram; released bus reads as all ones via tri1
module tb_bidir_ram;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] address = 0;
    logic       write = 1;
    logic [7:0] drv = 0;
    logic       drv_en = 0;
    tri1  [7:0] data;
    int checks = 0;
    int errors = 0;

    assign data = drv_en ? drv : 8'hzz;

    bidir_ram dut (.clk(clk), .rst_n(rst_n), .data(data), .address(address), .write(write));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        address = a;
        write = 1;
        drv_en = 0;
`ifdef RAM_OUTREG_EN
        tick();
`endif
        #1;
        chk(tag, data, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int n);
        address = a;
        drv = d;
        drv_en = 1;
        write = 0;
        repeat (n) tick();
        write = 1;
        drv_en = 0;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("reset_bus_hiz", data, 8'hFF);
        rst_n = 1;
        tick();
        for (int a = 0; a < 256; a++) rd("reset_sweep", 8'(a), 8'h00);
        rd("basic_pre", 8'h00, 8'h00);
        write = 0;
        #1;
        chk("write_bus_hiz", data, 8'hFF);
        wr(8'h00, 8'hAA, 5);
        rd("basic_read", 8'h00, 8'hAA);
        wr(8'h04, 8'hFE, 5);
        rd("second_read", 8'h04, 8'hFE);
        rd("first_again", 8'h00, 8'hAA);
        rd("second_again", 8'h04, 8'hFE);
        rd("gap_01", 8'h01, 8'h00);
        rd("gap_02", 8'h02, 8'h00);
        rd("gap_03", 8'h03, 8'h00);
        address = 8'h10;
        drv_en = 1;
        write = 0;
        drv = 8'h11;
        tick();
        drv = 8'h22;
        tick();
        drv = 8'h33;
        tick();
        rd("held_strobe", 8'h10, 8'h33);
        address = 8'h30;
        drv = 8'h44;
        drv_en = 1;
        write = 0;
        tick();
        address = 8'h31;
        drv = 8'h55;
        tick();
        rd("moving_addr_30", 8'h30, 8'h44);
        rd("moving_addr_31", 8'h31, 8'h55);
        wr(8'hFF, 8'h9C, 1);
        rd("top_addr", 8'hFF, 8'h9C);
        wr(8'h20, 8'h5A, 1);
        rd("pre_reset_20", 8'h20, 8'h5A);
        address = 8'h21;
        drv = 8'hC3;
        drv_en = 1;
        write = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        rd("post_reset_20", 8'h20, 8'h00);
        rd("post_reset_21", 8'h21, 8'h00);
        rd("post_reset_00", 8'h00, 8'h00);
`ifdef RAM_OUTREG_EN
        wr(8'h08, 8'h77, 1);
        address = 8'h08;
        #1;
        chk("outreg_held", data, 8'h00);
        tick();
        #1;
        chk("outreg_new", data, 8'h77);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
